// File: rtl/ddr4_app_pkg.sv
// rtl/ddr4_app_pkg.sv - shared constants, command codes and FSM state for the DDR4 app adapter
package ddr4_app_pkg;

  localparam int ADDR_W_DEF        = 28;
  localparam int DATA_W_DEF        = 640;
  localparam int MASK_W_DEF        = 80;
  localparam int RD_FIFO_DEPTH_DEF = 16;

  localparam logic [2:0] APP_CMD_WR = 3'b000;
  localparam logic [2:0] APP_CMD_RD = 3'b001;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

endpackage

// File: rtl/ddr4_rd_fifo.sv
// rtl/ddr4_rd_fifo.sv - synchronous show-ahead FIFO holding returned read bursts
module ddr4_rd_fifo #(
  parameter int DATA_W = 640,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign do_pop   = pop && !empty;
  // A pop frees the slot in the same cycle, so full-with-pop still accepts the push.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ddr4_app_adapter.sv
// rtl/ddr4_app_adapter.sv - request front-end driving the DDR4 controller app_* user interface
module ddr4_app_adapter
  import ddr4_app_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int MASK_W        = MASK_W_DEF,
  parameter int RD_FIFO_DEPTH = RD_FIFO_DEPTH_DEF,
  parameter int CNT_W         = $clog2(RD_FIFO_DEPTH) + 1
) (
  input  logic              c0_ddr4_ui_clk,
  input  logic              c0_ddr4_ui_clk_sync_rst,
  input  logic              c0_init_calib_complete,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [MASK_W-1:0] req_wmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] c0_ddr4_app_addr,
  output logic [2:0]        c0_ddr4_app_cmd,
  output logic              c0_ddr4_app_en,
  output logic              c0_ddr4_app_hi_pri,
  input  logic              c0_ddr4_app_rdy,
  output logic [DATA_W-1:0] c0_ddr4_app_wdf_data,
  output logic [MASK_W-1:0] c0_ddr4_app_wdf_mask,
  output logic              c0_ddr4_app_wdf_wren,
  output logic              c0_ddr4_app_wdf_end,
  input  logic              c0_ddr4_app_wdf_rdy,
  input  logic [DATA_W-1:0] c0_ddr4_app_rd_data,
  input  logic              c0_ddr4_app_rd_data_valid,
  input  logic              c0_ddr4_app_rd_data_end,
  output logic [CNT_W-1:0]  rd_outstanding
);

  logic              clk;
  logic              rst;
  state_t            state, state_nxt;
  logic              cmd_pend, cmd_pend_nxt;
  logic              data_pend, data_pend_nxt;
  logic [ADDR_W-1:0] hold_addr;
  logic [2:0]        hold_cmd;
  logic [DATA_W-1:0] hold_wdata;
  logic [MASK_W-1:0] hold_wmask;
  logic [CNT_W-1:0]  rd_cnt;
  logic              req_fire;
  logic              rsp_pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic              unused_inputs;

  assign clk = c0_ddr4_ui_clk;
  assign rst = c0_ddr4_ui_clk_sync_rst;

  assign unused_inputs = ^{c0_ddr4_app_rd_data_end, req_addr[2:0]};

  // Reads need a free credit; writes never consume FIFO space.
  assign req_ready = !rst && (state == IDLE) && c0_init_calib_complete &&
                     (req_write || (rd_cnt < CNT_W'(RD_FIFO_DEPTH)));
  assign req_fire  = req_valid && req_ready;
  assign rsp_pop   = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_pend  <= 1'b0;
      data_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      cmd_pend  <= cmd_pend_nxt;
      data_pend <= data_pend_nxt;
    end
  end

  always_comb begin
    state_nxt            = state;
    cmd_pend_nxt         = cmd_pend;
    data_pend_nxt        = data_pend;
    c0_ddr4_app_en       = 1'b0;
    c0_ddr4_app_wdf_wren = 1'b0;
    case (state)
      IDLE: begin
        if (req_fire) begin
          cmd_pend_nxt  = 1'b1;
          data_pend_nxt = req_write;
          state_nxt     = ISSUE;
        end
      end
      ISSUE: begin
        c0_ddr4_app_en       = cmd_pend;
        c0_ddr4_app_wdf_wren = data_pend;
        if (cmd_pend && c0_ddr4_app_rdy)      cmd_pend_nxt  = 1'b0;
        if (data_pend && c0_ddr4_app_wdf_rdy) data_pend_nxt = 1'b0;
        if (!cmd_pend_nxt && !data_pend_nxt)  state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_addr  <= '0;
      hold_cmd   <= APP_CMD_WR;
      hold_wdata <= '0;
      hold_wmask <= '0;
    end else if (req_fire) begin
      hold_addr  <= {req_addr[ADDR_W-1:3], 3'b000};
      hold_cmd   <= req_write ? APP_CMD_WR : APP_CMD_RD;
      hold_wdata <= req_wdata;
      hold_wmask <= req_wmask;
    end
  end

  assign c0_ddr4_app_addr     = hold_addr;
  assign c0_ddr4_app_cmd      = hold_cmd;
  assign c0_ddr4_app_wdf_data = hold_wdata;
  assign c0_ddr4_app_wdf_mask = hold_wmask;
  assign c0_ddr4_app_wdf_end  = c0_ddr4_app_wdf_wren;
  assign c0_ddr4_app_hi_pri   = 1'b0;

  // Credits cover both in-flight reads and buffered data, so the FIFO can never overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt <= '0;
    end else begin
      case ({req_fire && !req_write, rsp_pop})
        2'b10:   rd_cnt <= rd_cnt + 1'b1;
        2'b01:   rd_cnt <= rd_cnt - 1'b1;
        default: rd_cnt <= rd_cnt;
      endcase
    end
  end

  assign rd_outstanding = rd_cnt;

  ddr4_rd_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RD_FIFO_DEPTH),
    .CNT_W  (CNT_W)
  ) u_rd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (c0_ddr4_app_rd_data_valid),
    .push_data (c0_ddr4_app_rd_data),
    .pop       (rsp_ready),
    .pop_data  (rsp_data),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign rsp_valid = !fifo_empty;

  always_ff @(posedge clk) begin
    if (!rst && c0_ddr4_app_rd_data_valid) assert (!fifo_full);
  end

endmodule

// File: tb/tb_ddr4_app_adapter.sv
// tb/tb_ddr4_app_adapter.sv - directed self-checking bench for ddr4_app_adapter
module tb_ddr4_app_adapter;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 640;
  localparam int MASK_W = 80;
  localparam int CNT_W  = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              calib = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic [MASK_W-1:0] req_wmask = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_data;
  logic [ADDR_W-1:0] app_addr;
  logic [2:0]        app_cmd;
  logic              app_en;
  logic              app_hi_pri;
  logic              app_rdy = 1'b1;
  logic [DATA_W-1:0] wdf_data;
  logic [MASK_W-1:0] wdf_mask;
  logic              wdf_wren;
  logic              wdf_end;
  logic              wdf_rdy = 1'b1;
  logic [DATA_W-1:0] rd_data = '0;
  logic              rd_data_valid = 1'b0;
  logic [CNT_W-1:0]  rd_outstanding;

  int n_checks = 0;
  int n_fail   = 0;

  int                cmd_cnt = 0;
  int                wr_cnt  = 0;
  int                rd_tag  = 0;
  logic [DATA_W-1:0] last_wdata = '0;
  logic [DATA_W-1:0] ret_q[$];

  logic [DATA_W-1:0] pat_a;
  logic [DATA_W-1:0] pat_b;
  logic [MASK_W-1:0] mask_b;

  always #5 clk = ~clk;

  ddr4_app_adapter dut (
    .c0_ddr4_ui_clk            (clk),
    .c0_ddr4_ui_clk_sync_rst   (rst),
    .c0_init_calib_complete    (calib),
    .req_valid                 (req_valid),
    .req_ready                 (req_ready),
    .req_write                 (req_write),
    .req_addr                  (req_addr),
    .req_wdata                 (req_wdata),
    .req_wmask                 (req_wmask),
    .rsp_valid                 (rsp_valid),
    .rsp_ready                 (rsp_ready),
    .rsp_data                  (rsp_data),
    .c0_ddr4_app_addr          (app_addr),
    .c0_ddr4_app_cmd           (app_cmd),
    .c0_ddr4_app_en            (app_en),
    .c0_ddr4_app_hi_pri        (app_hi_pri),
    .c0_ddr4_app_rdy           (app_rdy),
    .c0_ddr4_app_wdf_data      (wdf_data),
    .c0_ddr4_app_wdf_mask      (wdf_mask),
    .c0_ddr4_app_wdf_wren      (wdf_wren),
    .c0_ddr4_app_wdf_end       (wdf_end),
    .c0_ddr4_app_wdf_rdy       (wdf_rdy),
    .c0_ddr4_app_rd_data       (rd_data),
    .c0_ddr4_app_rd_data_valid (rd_data_valid),
    .c0_ddr4_app_rd_data_end   (rd_data_valid),
    .rd_outstanding            (rd_outstanding)
  );

  // Controller model: handshakes are judged at the falling edge ahead of the rising edge
  // that completes them; each accepted read returns tag rd_tag one cycle later, in order.
  always @(negedge clk) begin
    rd_data_valid = 1'b0;
    if (rst) begin
      ret_q.delete();
      rd_tag = 0;
    end else begin
      if (ret_q.size() > 0) begin
        rd_data       = ret_q.pop_front();
        rd_data_valid = 1'b1;
      end
      if (app_en && app_rdy) begin
        cmd_cnt++;
        if (app_cmd == 3'b001) begin
          ret_q.push_back(DATA_W'(rd_tag));
          rd_tag++;
        end
      end
      if (wdf_wren && wdf_rdy) begin
        wr_cnt++;
        last_wdata = wdf_data;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic wr, input logic [ADDR_W-1:0] a, output bit ok);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (req_ready) ok = 1'b1;
      tick();
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    calib = 1'b1;
    tick(); tick(); tick();
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
    n_checks++; if (app_en !== 1'b0 || wdf_wren !== 1'b0) begin n_fail++; $display("FAIL rst_strobes: got en=%b wren=%b want 0/0", app_en, wdf_wren); end
    n_checks++; if (app_cmd !== 3'd0 || app_addr !== '0) begin n_fail++; $display("FAIL rst_cmd_addr: got cmd=%0h addr=%0h want 0/0", app_cmd, app_addr); end
    n_checks++; if (rsp_valid !== 1'b0 || rd_outstanding !== '0) begin n_fail++; $display("FAIL rst_rsp: got rsp_valid=%b outst=%0d want 0/0", rsp_valid, rd_outstanding); end
    n_checks++; if (app_hi_pri !== 1'b0) begin n_fail++; $display("FAIL hi_pri: got %b want 0", app_hi_pri); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write();
    int c0, w0;
    c0 = cmd_cnt; w0 = wr_cnt;
    app_rdy = 1'b1; wdf_rdy = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 28'h0000123; req_wdata = pat_a; req_wmask = '0;
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready: got %b want 1", req_ready); end
    tick();
    req_valid = 1'b0;
    #1;
    n_checks++; if (app_en !== 1'b1 || wdf_wren !== 1'b1 || wdf_end !== 1'b1) begin n_fail++; $display("FAIL wr_strobes: got en=%b wren=%b end=%b want 1/1/1", app_en, wdf_wren, wdf_end); end
    n_checks++; if (app_addr !== 28'h0000120 || app_cmd !== 3'b000) begin n_fail++; $display("FAIL wr_addr_cmd: got addr=%0h cmd=%0h want 120/0", app_addr, app_cmd); end
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL wr_busy: got req_ready=%b want 0", req_ready); end
    tick();
    n_checks++; if (app_en !== 1'b0 || wdf_wren !== 1'b0) begin n_fail++; $display("FAIL wr_one_cycle: got en=%b wren=%b want 0/0", app_en, wdf_wren); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready_back: got %b want 1", req_ready); end
    n_checks++; if (cmd_cnt - c0 !== 1 || wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL wr_counts: got cmd=%0d data=%0d want 1/1", cmd_cnt - c0, wr_cnt - w0); end
    n_checks++; if (last_wdata !== pat_a) begin n_fail++; $display("FAIL wr_data: got %h want %h", last_wdata, pat_a); end
  endtask

  task automatic test_split_handshake();
    int c0, w0, en_cycles, bad;
    c0 = cmd_cnt; w0 = wr_cnt; en_cycles = 0; bad = 0;
    app_rdy = 1'b1; wdf_rdy = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 28'h0000047; req_wdata = pat_b; req_wmask = mask_b;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) wdf_rdy = 1'b1;
      #1;
      if (app_en) en_cycles++;
      if (wdf_wren !== 1'b1 || wdf_data !== pat_b || wdf_mask !== mask_b) bad++;
      tick();
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL split_stable: got %0d unstable cycles want 0", bad); end
    n_checks++; if (en_cycles !== 1) begin n_fail++; $display("FAIL split_en_cycles: got %0d want 1", en_cycles); end
    n_checks++; if (wdf_wren !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL split_done: got wren=%b ready=%b want 0/1", wdf_wren, req_ready); end
    n_checks++; if (cmd_cnt - c0 !== 1 || wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL split_counts: got cmd=%0d data=%0d want 1/1", cmd_cnt - c0, wr_cnt - w0); end
  endtask

  task automatic test_read_credits();
    bit ok;
    int n_ok, c0;
    rst = 1'b1; tick(); rst = 1'b0; tick();
    app_rdy = 1'b1; wdf_rdy = 1'b1; rsp_ready = 1'b0;
    n_ok = 0;
    for (int k = 0; k < 16; k++) begin
      send(1'b0, ADDR_W'(k * 8), ok);
      if (ok) n_ok++;
    end
    repeat (4) tick();
    n_checks++; if (n_ok !== 16) begin n_fail++; $display("FAIL cr_accepts: got %0d want 16", n_ok); end
    n_checks++; if (rd_outstanding !== 5'd16) begin n_fail++; $display("FAIL cr_outst: got %0d want 16", rd_outstanding); end
    n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== DATA_W'(0)) begin n_fail++; $display("FAIL cr_head: got v=%b data=%0h want 1/0", rsp_valid, rsp_data); end
    c0 = cmd_cnt;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 28'h0000800;
    repeat (3) tick();
    n_checks++; if (req_ready !== 1'b0 || cmd_cnt !== c0) begin n_fail++; $display("FAIL cr_17th_blocked: got ready=%b cmds=%0d want 0/0", req_ready, cmd_cnt - c0); end
    rsp_ready = 1'b1;
    #1;
    n_checks++; if (rsp_data !== DATA_W'(0)) begin n_fail++; $display("FAIL cr_pop0: got %0h want 0", rsp_data); end
    tick();
    rsp_ready = 1'b0;
    #1;
    n_checks++; if (req_ready !== 1'b1 || rsp_data !== DATA_W'(1)) begin n_fail++; $display("FAIL cr_after_pop: got ready=%b data=%0h want 1/1", req_ready, rsp_data); end
    tick();
    req_valid = 1'b0;
    #1;
    n_checks++; if (rd_outstanding !== 5'd16) begin n_fail++; $display("FAIL cr_refill: got %0d want 16", rd_outstanding); end
    repeat (4) tick();
  endtask

  task automatic test_pop_and_accept();
    bit got;
    int bad;
    rsp_ready = 1'b1;
    #1;
    n_checks++; if (rsp_data !== DATA_W'(1)) begin n_fail++; $display("FAIL pa_head1: got %0h want 1", rsp_data); end
    tick();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 28'h0000900;
    #1;
    n_checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b1 || rsp_data !== DATA_W'(2)) begin n_fail++; $display("FAIL pa_both: got ready=%b v=%b data=%0h want 1/1/2", req_ready, rsp_valid, rsp_data); end
    n_checks++; if (rd_outstanding !== 5'd15) begin n_fail++; $display("FAIL pa_before: got %0d want 15", rd_outstanding); end
    tick();
    req_valid = 1'b0; rsp_ready = 1'b0;
    #1;
    n_checks++; if (rd_outstanding !== 5'd15) begin n_fail++; $display("FAIL pa_unchanged: got %0d want 15", rd_outstanding); end
    rsp_ready = 1'b1;
    bad = 0;
    for (int e = 3; e <= 17; e++) begin
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        #1;
        if (rsp_valid) begin
          got = 1'b1;
          if (rsp_data !== DATA_W'(e)) begin bad++; $display("FAIL pa_order: got %0h want %0h", rsp_data, e); end
        end
        tick();
      end
      if (!got) begin bad++; $display("FAIL pa_timeout: no rsp for %0d", e); end
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL pa_drain: got %0d errors want 0", bad); end
    rsp_ready = 1'b0;
    #1;
    n_checks++; if (rd_outstanding !== '0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL pa_empty: got outst=%0d v=%b want 0/0", rd_outstanding, rsp_valid); end
  endtask

  task automatic test_calib_gating();
    int bad_ready, bad_en;
    bad_ready = 0; bad_en = 0;
    calib = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 28'h0000200; req_wdata = pat_a;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (req_ready !== 1'b0) bad_ready++;
      if (app_en !== 1'b0) bad_en++;
      tick();
    end
    n_checks++; if (bad_ready !== 0 || bad_en !== 0) begin n_fail++; $display("FAIL cal_gate: got ready_hi=%0d en_hi=%0d want 0/0", bad_ready, bad_en); end
    calib = 1'b1;
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL cal_accept: got %b want 1", req_ready); end
    tick();
    req_valid = 1'b0;
    #1;
    n_checks++; if (app_en !== 1'b1 || app_addr !== 28'h0000200) begin n_fail++; $display("FAIL cal_issue: got en=%b addr=%0h want 1/200", app_en, app_addr); end
    repeat (2) tick();
  endtask

  task automatic test_reset_mid_issue();
    bit ok;
    rsp_ready = 1'b0; app_rdy = 1'b1;
    send(1'b0, 28'h0000300, ok);
    repeat (4) tick();
    app_rdy = 1'b0;
    send(1'b0, 28'h0000308, ok);
    #1;
    n_checks++; if (app_en !== 1'b1 || rsp_valid !== 1'b1 || rd_outstanding !== 5'd2) begin n_fail++; $display("FAIL rm_pre: got en=%b v=%b outst=%0d want 1/1/2", app_en, rsp_valid, rd_outstanding); end
    rst = 1'b1;
    tick();
    n_checks++; if (app_en !== 1'b0 || rsp_valid !== 1'b0 || rd_outstanding !== '0 || req_ready !== 1'b0) begin n_fail++; $display("FAIL rm_post: got en=%b v=%b outst=%0d ready=%b want 0/0/0/0", app_en, rsp_valid, rd_outstanding, req_ready); end
    rst = 1'b0; app_rdy = 1'b1;
    tick();
  endtask

  initial begin
    pat_a  = {20{32'hA5A5_1234}};
    pat_b  = {20{32'h5A5A_C0DE}};
    mask_b = {10{8'h3C}};
    test_reset();
    test_write();
    test_split_handshake();
    test_read_credits();
    test_pop_and_accept();
    test_calib_gating();
    test_reset_mid_issue();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
